ram_port_arbiter: RTL and testbench

- Shares one port of the dual-port block RAM among NUM_REQ requesters.
- Arbitrates round-robin and drives the RAM port (en/we/addr/din); the RAM returns data one cycle after en.
- Routes each read/write response back to the requester that issued it.
- Supports locked sequences (e.g. read-modify-write) that keep the grant across beats.
- Sits between control-path clients (register banks, table loaders) and the RAM; the other RAM port stays free for the datapath.

---
 rtl/ram_port_arbiter_pkg.sv | 22 ++
 rtl/ram_port_arbiter_rr_pick.sv | 37 +++
 rtl/ram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter.
// Lanes are extracted from buses zero-extended to LANE_BUS_W, so lanes are at most 64 bits and there are at most 8 requesters.
package ram_port_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Cycles from accept to rsp_valid: RAM-drive register, RAM output register, response register.
  localparam int RSP_LATENCY = 3;

  localparam int LANE_MAX_W = 64;
  localparam int LANE_BUS_W = 8 * LANE_MAX_W;

  function automatic logic [LANE_MAX_W-1:0] get_lane(input logic [LANE_BUS_W-1:0] bus,
                                                     input int idx,
                                                     input int width);
    return LANE_MAX_W'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by the pointer, take the
// lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;

  logic [NUM_REQ-1:0] rot;
  logic [PW-1:0]      off;
  logic               found;
  logic [SW-1:0]      sum;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    rot   = NUM_REQ'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = PW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
    idx   = sum[PW-1:0];
    grant = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ requesters,
// with locked multi-beat sequences and fixed-latency response routing.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 9
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [AWIDTH-1:0]         ram_addr,
  output logic [DWIDTH-1:0]         ram_wdata,
  input  logic [DWIDTH-1:0]         ram_rdata
);

  localparam int PW     = $clog2(NUM_REQ);
  localparam int PIPE_D = RSP_LATENCY - 1;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [PW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      acc_idx;
  logic               accept;
  logic               acc_we;
  logic               acc_lock;
  logic [AWIDTH-1:0]  acc_addr;
  logic [DWIDTH-1:0]  acc_wdata;

  logic [PIPE_D-1:0]  pipe_vld;
  logic [PW-1:0]      pipe_id [PIPE_D];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // While locked, the owner's own valid is the whole grant decision.
  always_comb begin
    grant   = '0;
    acc_idx = pick_idx;
    if (state_q == IDLE) begin
      grant = pick_grant;
    end else begin
      acc_idx        = owner_q;
      grant[owner_q] = req_valid[owner_q];
    end
  end

  // Ready is forced low while reset is asserted so nothing looks accepted.
  assign req_ready = reset_n ? grant : '0;
  assign accept    = |req_ready;
  assign acc_we    = req_we[acc_idx];
  assign acc_lock  = req_lock[acc_idx];
  assign acc_addr  = AWIDTH'(get_lane(LANE_BUS_W'(req_addr), int'(acc_idx), AWIDTH));
  assign acc_wdata = DWIDTH'(get_lane(LANE_BUS_W'(req_wdata), int'(acc_idx), DWIDTH));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (accept) begin
      if (acc_lock) begin
        state_d = LOCKED;
        owner_d = acc_idx;
      end else begin
        state_d = IDLE;
        ptr_d   = (acc_idx == PW'(NUM_REQ - 1)) ? '0 : acc_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= accept;
      ram_we <= accept & acc_we;
      if (accept) begin
        ram_addr  <= acc_addr;
        ram_wdata <= acc_wdata;
      end
    end
  end

  // Requester IDs ride alongside the RAM access; only the valid bits are flushed by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe_vld <= '0;
    else          pipe_vld <= {pipe_vld[PIPE_D-2:0], accept};
  end

  // NOTE: ID stages have no reset; they are only read when the matching valid bit is set.
  always_ff @(posedge clk) begin
    pipe_id[0] <= acc_idx;
    for (int k = 1; k < PIPE_D; k++) pipe_id[k] <= pipe_id[k-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= pipe_vld[PIPE_D-1] ? (NUM_REQ'(1) << pipe_id[PIPE_D-1]) : '0;
      if (pipe_vld[PIPE_D-1]) rsp_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a read-first registered RAM model.
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_wdata;
  logic [DW-1:0]   ram_rdata = '0;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;

  logic [DW-1:0]   mem [0:511];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '1;
    req_we    = '0;
    req_lock  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_wdata} !== '0)
      $display("FAIL reset_outputs ready=%b rsp=%b rdata=%h en=%b we=%b addr=%h wdata=%h (want all 0)",
               req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_wdata);
    else n_pass++;
    next_cycle();
    reset_n   = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single_read();
    mem[5] = 32'hA5A5_0001;
    set_lane(0, 9'd5, '0);
    req_we = '0; req_lock = '0; req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready);
    else n_pass++;
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 9'd5})
      $display("FAIL single_ram_drive got en=%b we=%b addr=%0d want en=1 we=0 addr=5", ram_en, ram_we, ram_addr);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_early got %b want 0000", rsp_valid);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got %b want 0001", rsp_valid);
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== 32'hA5A5_0001) $display("FAIL single_rsp_rdata got %h want a5a50001", rsp_rdata);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_rdata, ram_en} !== {4'b0000, 32'hA5A5_0001, 1'b0})
      $display("FAIL single_hold got rsp=%b rdata=%h en=%b want 0000 a5a50001 0", rsp_valid, rsp_rdata, ram_en);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_fairness();
    logic [N-1:0]  exp_ready, exp_rsp;
    logic [DW-1:0] exp_data;
    test_reset();
    for (int i = 0; i < N; i++) begin
      mem[16+i] = 32'h100 + i;
      set_lane(i, AW'(16 + i), '0);
    end
    req_we = '0; req_lock = '0;
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      exp_ready = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      exp_rsp   = (c >= 3) ? (4'b0001 << ((c - 3) % 4)) : 4'b0000;
      exp_data  = 32'h100 + ((c - 3) % 4);
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_ready) $display("FAIL fair_ready c=%0d got %b want %b", c, req_ready, exp_ready);
      else n_pass++;
      if (c >= 1 && c <= 8) begin
        n_checks++;
        if (ram_addr !== AW'(16 + (c - 1) % 4))
          $display("FAIL fair_addr c=%0d got %0d want %0d", c, ram_addr, 16 + (c - 1) % 4);
        else n_pass++;
      end
      n_checks++;
      if (rsp_valid !== exp_rsp) $display("FAIL fair_rsp c=%0d got %b want %b", c, rsp_valid, exp_rsp);
      else n_pass++;
      if (c >= 3) begin
        n_checks++;
        if (rsp_rdata !== exp_data) $display("FAIL fair_rdata c=%0d got %h want %h", c, rsp_rdata, exp_data);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_write_read_first();
    mem[7] = 32'h11;
    set_lane(2, 9'd7, 32'h22);
    req_we = 4'b0100; req_lock = '0; req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) $display("FAIL wr_ready got %b want 0100", req_ready);
    else n_pass++;
    next_cycle();
    req_we = '0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) $display("FAIL rd_after_wr_ready got %b want 0100", req_ready);
    else n_pass++;
    n_checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 9'd7, 32'h22})
      $display("FAIL wr_ram_drive got en=%b we=%b addr=%0d wdata=%h want 1 1 7 22", ram_en, ram_we, ram_addr, ram_wdata);
    else n_pass++;
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if ({ram_en, ram_we} !== 2'b10) $display("FAIL rd_ram_drive got en=%b we=%b want 1 0", ram_en, ram_we);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {4'b0100, 32'h11})
      $display("FAIL wr_old_data got rsp=%b rdata=%h want 0100 00000011", rsp_valid, rsp_rdata);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {4'b0100, 32'h22})
      $display("FAIL rd_new_data got rsp=%b rdata=%h want 0100 00000022", rsp_valid, rsp_rdata);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_lock();
    logic [N-1:0] v_tab [8];
    logic [N-1:0] l_tab [8];
    logic [N-1:0] r_tab [8];
    v_tab = '{4'b1011, 4'b1011, 4'b1011, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    l_tab = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    r_tab = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    test_reset();
    req_we = '0; req_lock = '0;
    for (int i = 0; i < N; i++) set_lane(i, AW'(32 + i), '0);
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL lock_setup_ready got %b want 0001", req_ready);
    else n_pass++;
    next_cycle();
    req_valid = '0;
    repeat (4) next_cycle();
    for (int c = 0; c < 8; c++) begin
      req_valid = v_tab[c];
      req_lock  = l_tab[c];
      @(negedge clk);
      n_checks++;
      if (req_ready !== r_tab[c]) $display("FAIL lock_ready c=%0d got %b want %b", c, req_ready, r_tab[c]);
      else n_pass++;
      n_checks++;
      if (rsp_valid !== ((c >= 3) ? r_tab[c-3] : 4'b0000))
        $display("FAIL lock_rsp c=%0d got %b want %b", c, rsp_valid, (c >= 3) ? r_tab[c-3] : 4'b0000);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_lock_hold();
    logic [N-1:0] v_tab [8];
    logic [N-1:0] l_tab [8];
    logic [N-1:0] r_tab [8];
    v_tab = '{4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
    l_tab = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    r_tab = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    for (int c = 0; c < 8; c++) begin
      req_valid = v_tab[c];
      req_lock  = l_tab[c];
      @(negedge clk);
      n_checks++;
      if (req_ready !== r_tab[c]) $display("FAIL hold_ready c=%0d got %b want %b", c, req_ready, r_tab[c]);
      else n_pass++;
      next_cycle();
    end
    req_valid = '0;
    req_lock  = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_reset_midflight();
    test_reset();
    req_we = '0; req_lock = '0;
    for (int i = 0; i < N; i++) set_lane(i, AW'(48 + i), '0);
    req_valid = 4'b0100;
    next_cycle();
    req_valid = '0;
    repeat (4) next_cycle();
    req_valid = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL mid_first_ready got %b want 1000", req_ready);
    else n_pass++;
    next_cycle();
    req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL mid_second_ready got %b want 0010", req_ready);
    else n_pass++;
    next_cycle();
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_wdata} !== '0)
      $display("FAIL mid_async_clear ready=%b rsp=%b rdata=%h en=%b we=%b addr=%h wdata=%h (want all 0)",
               req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_wdata);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 4'b0000) $display("FAIL mid_no_rsp c=%0d got %b want 0000", c, rsp_valid);
      else n_pass++;
      next_cycle();
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL mid_release_ready got %b want 0001", req_ready);
    else n_pass++;
    next_cycle();
    req_valid = '0;
    repeat (4) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_single_read();
    test_fairness();
    test_write_read_first();
    test_lock();
    test_lock_hold();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
